bit_serializer: RTL and testbench

- Parallel-to-serial front end for the single-bit sequence detectors (e.g. the "101" Moore detector).
- Accepts WIDTH-bit words over a valid/ready handshake and shifts each word out one bit per clock on ser_out, which drives the detector's serial input I directly.
- Holds ser_out at a fixed idle level between words, because the detector samples its input on every clock.
- Supports back-to-back words with no bubble cycle.

---
 rtl/bit_serializer.sv | 71 +++++++
 tb/tb_bit_serializer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial shifter feeding a single-bit sequence detector
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n, src, shifted;
  logic out_n, last_n, accept, head;
  assign in_ready  = !rst && (state == IDLE || cnt == LAST);
  assign accept    = in_valid && in_ready;
  assign src       = accept ? in_data : sreg;
  assign head      = MSB_FIRST ? src[WIDTH-1] : src[0];
  assign shifted   = MSB_FIRST ? src << 1 : src >> 1;
  assign ser_valid = state == SHIFT;
  assign busy      = ser_valid;
  // next-state: load on accept, advance mid-word, drop to idle after the last bit
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    out_n   = IDLE_BIT;
    last_n  = 1'b0;
    if (accept) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sreg_n  = shifted;
      out_n   = head;
      last_n  = LAST == '0;
    end else if (state == SHIFT && cnt != LAST) begin
      cnt_n  = cnt + CW'(1);
      sreg_n = shifted;
      out_n  = head;
      last_n = (cnt + CW'(1)) == LAST;
    end else if (state == SHIFT) begin
      state_n = IDLE;
      cnt_n   = '0;
      sreg_n  = '0;
    end
  end
  // state and registered serial outputs; reset clears the word in flight immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sreg     <= '0;
      ser_out  <= IDLE_BIT;
      ser_last <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sreg     <= sreg_n;
      ser_out  <= out_n;
      ser_last <= last_n;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of the serializer in MSB, LSB and single-bit configurations
module tb_bit_serializer;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] d0 = '0, d1 = '0;
  logic [0:0] d2 = '0;
  logic v0 = 0, v1 = 0, v2 = 0;
  logic r0, o0, sv0, sl0, b0;
  logic r1, o1, sv1, sl1, b1;
  logic r2, o2, sv2, sl2, b2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0),
    .ser_out(o0), .ser_valid(sv0), .ser_last(sl0), .busy(b0));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1),
    .ser_out(o1), .ser_valid(sv1), .ser_last(sl1), .busy(b1));
  bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2),
    .ser_out(o2), .ser_valid(sv2), .ser_last(sl2), .busy(b2));

  task automatic test_reset;
    @(posedge clk); #1;
    total++; if (o0 !== 1'b0) begin bad++; $display("FAIL rst_out0 got=%b exp=0", o0); end
    total++; if (sv0 !== 1'b0 || sl0 !== 1'b0 || b0 !== 1'b0) begin bad++; $display("FAIL rst_flags0 got=%b%b%b exp=000", sv0, sl0, b0); end
    total++; if (r0 !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b exp=0", r0); end
    total++; if (o2 !== 1'b1) begin bad++; $display("FAIL rst_out2 got=%b exp=1", o2); end
    total++; if (sv2 !== 1'b0 || r2 !== 1'b0) begin bad++; $display("FAIL rst_flags2 got=%b%b exp=00", sv2, r2); end
    @(negedge clk); rst = 1'b0; #1;
    total++; if (r0 !== 1'b1 || r1 !== 1'b1 || r2 !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b%b%b exp=111", r0, r1, r2); end
  endtask

  task automatic test_single;
    logic [7:0] pat = 8'hA5;
    logic [2:0] hist = '0;
    logic eo, ev, el, ed;
    @(posedge clk); #1 v0 = 1; d0 = pat;
    @(posedge clk); #1 v0 = 0; d0 = 'x;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      eo = k <= 8 ? pat[8-k] : 1'b0;
      ev = k <= 8;
      el = k == 8;
      ed = k == 3 || k == 8;
      hist = {hist[1:0], o0};
      total++; if (o0 !== eo) begin bad++; $display("FAIL single_out c%0d got=%b exp=%b", k, o0, eo); end
      total++; if (sv0 !== ev || b0 !== ev) begin bad++; $display("FAIL single_valid c%0d got=%b/%b exp=%b", k, sv0, b0, ev); end
      total++; if (sl0 !== el) begin bad++; $display("FAIL single_last c%0d got=%b exp=%b", k, sl0, el); end
      total++; if ((hist == 3'b101) !== ed) begin bad++; $display("FAIL single_det101 c%0d got=%b exp=%b", k, hist == 3'b101, ed); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] pat = 16'hA55A;
    logic eo, er;
    @(posedge clk); #1 v0 = 1; d0 = 8'hA5;
    @(negedge clk);
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL b2b_ready c0 got=%b exp=1", r0); end
    @(posedge clk); #1 d0 = 8'h5A;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      eo = k <= 16 ? pat[16-k] : 1'b0;
      er = k == 8 || k >= 16;
      total++; if (o0 !== eo) begin bad++; $display("FAIL b2b_out c%0d got=%b exp=%b", k, o0, eo); end
      total++; if (sv0 !== (k <= 16)) begin bad++; $display("FAIL b2b_valid c%0d got=%b exp=%b", k, sv0, k <= 16); end
      total++; if (r0 !== er) begin bad++; $display("FAIL b2b_ready c%0d got=%b exp=%b", k, r0, er); end
      total++; if (sl0 !== (k == 8 || k == 16)) begin bad++; $display("FAIL b2b_last c%0d got=%b exp=%b", k, sl0, k == 8 || k == 16); end
      if (k == 8) begin @(posedge clk); #1 v0 = 0; end
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] pat = 8'h05;
    logic eo;
    @(posedge clk); #1 v1 = 1; d1 = pat;
    @(posedge clk); #1 v1 = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      eo = k <= 8 ? pat[k-1] : 1'b0;
      total++; if (o1 !== eo) begin bad++; $display("FAIL lsb_out c%0d got=%b exp=%b", k, o1, eo); end
      total++; if (sv1 !== (k <= 8) || sl1 !== (k == 8)) begin bad++; $display("FAIL lsb_flags c%0d got=%b%b exp=%b%b", k, sv1, sl1, k <= 8, k == 8); end
    end
  endtask

  task automatic test_stall;
    logic [15:0] pat = 16'hC33C;
    logic eo;
    @(posedge clk); #1 v0 = 0; d0 = 8'h77;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (o0 !== 1'b0 || sv0 !== 1'b0 || r0 !== 1'b1) begin bad++; $display("FAIL stall_idle c%0d got=%b%b%b exp=001", k, o0, sv0, r0); end
    end
    @(posedge clk); #1 v0 = 1; d0 = 8'hC3;
    @(posedge clk); #1 d0 = 8'hFF;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      eo = k <= 16 ? pat[16-k] : 1'b0;
      total++; if (o0 !== eo) begin bad++; $display("FAIL stall_out c%0d got=%b exp=%b", k, o0, eo); end
      total++; if (r0 !== (k == 8 || k >= 16)) begin bad++; $display("FAIL stall_ready c%0d got=%b exp=%b", k, r0, k == 8 || k >= 16); end
      total++; if (sv0 !== (k <= 16)) begin bad++; $display("FAIL stall_valid c%0d got=%b exp=%b", k, sv0, k <= 16); end
      if (k < 7) d0 = 8'(k * 37);
      if (k == 7) d0 = 8'h3C;
      if (k == 8) begin @(posedge clk); #1 v0 = 0; end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] pat = 8'h81;
    @(posedge clk); #1 v0 = 1; d0 = 8'hFF;
    @(posedge clk); #1 v0 = 0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    total++; if (o0 !== 1'b1 || sv0 !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b%b exp=11", o0, sv0); end
    #1 rst = 1; #1;
    total++; if (o0 !== 1'b0 || sv0 !== 1'b0) begin bad++; $display("FAIL mid_async got=%b%b exp=00", o0, sv0); end
    total++; if (sl0 !== 1'b0 || b0 !== 1'b0 || r0 !== 1'b0) begin bad++; $display("FAIL mid_async_flags got=%b%b%b exp=000", sl0, b0, r0); end
    @(posedge clk); #1;
    total++; if (o0 !== 1'b0 || sv0 !== 1'b0) begin bad++; $display("FAIL mid_held got=%b%b exp=00", o0, sv0); end
    @(negedge clk); rst = 0; #1;
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%b exp=1", r0); end
    @(negedge clk);
    total++; if (o0 !== 1'b0 || sv0 !== 1'b0) begin bad++; $display("FAIL mid_no_resume got=%b%b exp=00", o0, sv0); end
    @(posedge clk); #1 v0 = 1; d0 = pat;
    @(posedge clk); #1 v0 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++; if (o0 !== pat[8-k] || sv0 !== 1'b1) begin bad++; $display("FAIL mid_next c%0d got=%b%b exp=%b1", k, o0, sv0, pat[8-k]); end
    end
  endtask

  task automatic test_width1;
    logic [2:0] pat = 3'b101;
    @(posedge clk); #1 v2 = 1; d2 = pat[2];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) d2 = pat[1-i]; else v2 = 0;
      @(negedge clk);
      total++; if (o2 !== pat[2-i]) begin bad++; $display("FAIL w1_out c%0d got=%b exp=%b", i + 1, o2, pat[2-i]); end
      total++; if (sv2 !== 1'b1 || sl2 !== 1'b1 || r2 !== 1'b1) begin bad++; $display("FAIL w1_flags c%0d got=%b%b%b exp=111", i + 1, sv2, sl2, r2); end
    end
    @(negedge clk);
    total++; if (o2 !== 1'b1 || sv2 !== 1'b0 || sl2 !== 1'b0) begin bad++; $display("FAIL w1_idle got=%b%b%b exp=100", o2, sv2, sl2); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_lsb_first;
    test_stall;
    test_reset_mid;
    test_width1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
